// File: rtl/alu_result_capture.sv
// alu_result_capture
// Small FIFO that buffers add/sub stage results for a downstream consumer over
// a valid/ready handshake, while keeping saturating counts of zero and
// negative results.
// Optional feature: define ALU_CAPTURE_CHECK_EN to enable the sticky
// malformed-result flag 'err'. Without it, err is tied to 0.
module alu_result_capture #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_c,
  input  logic                     in_sign,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_c,
  output logic                     out_sign,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         zero_cnt,
  output logic [CNT_W-1:0]         neg_cnt,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Each entry holds {c[3:0], sign, zero} exactly as received.
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [5:0]    head;
  logic          push;
  logic          pop;

  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head     = mem[rd_ptr];
  assign out_c    = out_valid ? head[5:2] : 4'd0;
  assign out_sign = out_valid ? head[1]   : 1'b0;
  assign out_zero = out_valid ? head[0]   : 1'b0;

  // Storage array; stale contents are hidden by out_valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_c, in_sign, in_zero};
    end
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Saturating statistics on accepted results; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt <= '0;
      neg_cnt  <= '0;
    end else if (clr_stats) begin
      zero_cnt <= '0;
      neg_cnt  <= '0;
    end else if (push) begin
      if (in_zero && (zero_cnt != '1)) zero_cnt <= zero_cnt + CNT_W'(1);
      if (in_sign && !in_zero && (neg_cnt != '1)) neg_cnt <= neg_cnt + CNT_W'(1);
    end
  end

`ifdef ALU_CAPTURE_CHECK_EN
  logic malformed;

  // A result is malformed if its flags disagree with its value or bit2 is set.
  always_comb begin
    malformed = 1'b0;
    if (in_sign != in_c[3])                 malformed = 1'b1;
    if (in_zero != (in_c[2:0] == 3'd0))     malformed = 1'b1;
    if (in_c[2])                            malformed = 1'b1;
    if (in_zero && in_sign)                 malformed = 1'b1;
  end

  // Sticky error flag, set by any malformed push and cleared only by clr_stats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clr_stats) begin
      err <= 1'b0;
    end else if (push && malformed) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// tb_alu_result_capture
// Randomized and directed stimulus for alu_result_capture, compared every
// cycle against a queue-based model of the buffer and its statistics.
// Honors ALU_CAPTURE_CHECK_EN the same way the design does.
module tb_alu_result_capture;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ALU_CAPTURE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_c;
  logic             in_sign;
  logic             in_zero;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_c;
  logic             out_sign;
  logic             out_zero;
  logic [2:0]       level;
  logic             clr_stats;
  logic [CNT_W-1:0] zero_cnt;
  logic [CNT_W-1:0] neg_cnt;
  logic             err;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  alu_result_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_c(in_c), .in_sign(in_sign), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_sign(out_sign), .out_zero(out_zero),
    .level(level), .clr_stats(clr_stats),
    .zero_cnt(zero_cnt), .neg_cnt(neg_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Model state: queue of {c, sign, zero}, plain integer counters, err flag
  logic [5:0] mq[$];
  int         mzero;
  int         mneg;
  bit         merr;
  bit         mpush;
  bit         mpop;

  function automatic bit is_malformed(input logic [3:0] c, input logic s, input logic z);
    return (s != c[3]) || (z != (c[2:0] == 3'd0)) || c[2] || (z && s);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: advances on the same edges as the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mzero = 0;
      mneg  = 0;
      merr  = 1'b0;
    end else begin
      mpush = in_valid && (mq.size() < DEPTH);
      mpop  = out_ready && (mq.size() != 0);
      if (mpush) begin
        if (in_zero && mzero < CNT_MAX) mzero++;
        if (in_sign && !in_zero && mneg < CNT_MAX) mneg++;
        if (CHECK_EN && is_malformed(in_c, in_sign, in_zero)) merr = 1'b1;
      end
      if (clr_stats) begin
        mzero = 0;
        mneg  = 0;
        merr  = 1'b0;
      end
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back({in_c, in_sign, in_zero});
    end
  end

  // Compare process: checks all outputs against the model on the falling edge
  always @(negedge clk) begin
    logic [5:0] h;
    if (checking && !rst) begin
      h = (mq.size() != 0) ? mq[0] : 6'd0;
      checkOutput("level",     level,     mq.size());
      checkOutput("out_valid", out_valid, mq.size() != 0);
      checkOutput("in_ready",  in_ready,  mq.size() != DEPTH);
      checkOutput("out_c",     out_c,     h[5:2]);
      checkOutput("out_sign",  out_sign,  h[1]);
      checkOutput("out_zero",  out_zero,  h[0]);
      checkOutput("zero_cnt",  zero_cnt,  mzero);
      checkOutput("neg_cnt",   neg_cnt,   mneg);
      checkOutput("err",       err,       merr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic s,
                               input logic z, input logic ord, input logic clr);
    in_valid  = v;
    in_c      = c;
    in_sign   = s;
    in_zero   = z;
    out_ready = ord;
    clr_stats = clr;
    tick();
  endtask

  initial begin
    logic [3:0] exp_heads [4];
    exp_heads[0] = 4'b0011;
    exp_heads[1] = 4'b1001;
    exp_heads[2] = 4'b0000;
    exp_heads[3] = 4'b1010;

    rst = 1'b1;
    in_valid = 0; in_c = 0; in_sign = 0; in_zero = 0; out_ready = 0; clr_stats = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset level",     level,     0);
    checkOutput("reset in_ready",  in_ready,  1);
    checkOutput("reset out_valid", out_valid, 0);
    rst = 1'b0;
    checking = 1'b1;

    // Reset in the middle of traffic
    $display("[TB] reset mid-traffic");
    applyStimulus(1, 4'b0001, 0, 0, 0, 0);
    applyStimulus(1, 4'b0000, 0, 1, 0, 0);
    applyStimulus(1, 4'b1011, 1, 0, 0, 0);
    in_valid = 0;
    checkOutput("pre-reset level", level, 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async level",     level,     0);
    checkOutput("async out_valid", out_valid, 0);
    checkOutput("async in_ready",  in_ready,  1);
    checkOutput("async out_c",     out_c,     0);
    checkOutput("async out_sign",  out_sign,  0);
    checkOutput("async out_zero",  out_zero,  0);
    checkOutput("async zero_cnt",  zero_cnt,  0);
    checkOutput("async neg_cnt",   neg_cnt,   0);
    checkOutput("async err",       err,       0);
    tick();
    rst = 1'b0;

    // Fill to full, hold a fifth push, then drain in order
    $display("[TB] fill and drain");
    applyStimulus(1, 4'b0011, 0, 0, 0, 0);
    applyStimulus(1, 4'b1001, 1, 0, 0, 0);
    applyStimulus(1, 4'b0000, 0, 1, 0, 0);
    applyStimulus(1, 4'b1010, 1, 0, 0, 0);
    checkOutput("full level",    level,    4);
    checkOutput("full in_ready", in_ready, 0);
    applyStimulus(1, 4'b0000, 0, 1, 0, 0);
    checkOutput("held level",    level,    4);
    checkOutput("held zero_cnt", zero_cnt, 1);
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain order", out_c, exp_heads[i]);
      tick();
    end
    checkOutput("drained level", level,    0);
    checkOutput("drain zero_cnt", zero_cnt, 1);
    checkOutput("drain neg_cnt",  neg_cnt,  2);

    // Simultaneous push and pop at level 2 across pointer wrap
    $display("[TB] push/pop at level 2");
    applyStimulus(1, 4'b0001, 0, 0, 0, 0);
    applyStimulus(1, 4'b1010, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1, 0);
      checkOutput("steady level", level, 2);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Counter saturation
    $display("[TB] saturation");
    applyStimulus(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 300; i++) applyStimulus(1, 4'b0000, 0, 1, 1, 0);
    checkOutput("sat zero_cnt", zero_cnt, 255);
    checkOutput("sat neg_cnt",  neg_cnt,  0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Clear has priority over a same-cycle increment
    $display("[TB] clear priority");
    applyStimulus(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 4'b0000, 0, 1, 1, 0);
    checkOutput("five zero_cnt", zero_cnt, 5);
    applyStimulus(1, 4'b0000, 0, 1, 1, 1);
    checkOutput("clr zero_cnt", zero_cnt, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Malformed result: bit2 set with zero flag clear
    $display("[TB] error check");
    applyStimulus(1, 4'b0100, 0, 0, 0, 0);
    checkOutput("err set",       err,   CHECK_EN);
    checkOutput("err entry c",   out_c, 4'b0100);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("err sticky",    err,   CHECK_EN);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("err popped",    level, 0);
    checkOutput("err held",      err,   CHECK_EN);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("err cleared",   err,   0);

    // Randomized traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
